// File: rtl/dsc_cache_reader.sv
// Descriptor cache reader: tracks slots written into a small SRAM, reads them back in push order
// through a 2-cycle SRAM read pipe and presents them downstream through a 2-entry credit-managed buffer.
module dsc_cache_reader #(
    parameter int DSC_WIDTH = 88,
    parameter int SLOT_BITS = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FLUSH,
    input  logic                 WR_PUSH,
    output logic [SLOT_BITS-1:0] WR_SLOT,
    output logic                 WR_FULL,
    output logic                 OVF,
    output logic [SLOT_BITS-1:0] RAM_R_ADDR,
    output logic                 RAM_R_ADDR_EN,
    output logic                 RAM_R_DATA_EN,
    input  logic [DSC_WIDTH-1:0] RAM_R_DATA,
    output logic                 DSC_VALID,
    input  logic                 DSC_READY,
    output logic [DSC_WIDTH-1:0] DSC_DATA,
    output logic [SLOT_BITS-1:0] DSC_SLOT,
    output logic [SLOT_BITS:0]   COUNT
);

    localparam int PW = SLOT_BITS + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2 ** SLOT_BITS);

    logic [PW-1:0]        wr_ptr_r, iss_ptr_r, free_ptr_r, count_s;
    logic                 ovf_r, full_s;
    logic                 s1_vld_r, s2_vld_r;
    logic [SLOT_BITS-1:0] s1_slot_r, s2_slot_r;
    logic [DSC_WIDTH-1:0] buf_data_r [2];
    logic [SLOT_BITS-1:0] buf_slot_r [2];
    logic                 buf_rd_r, buf_wr_r;
    logic [1:0]           buf_cnt_r, occ_s;
    logic                 push_ok_s, issue_s, pop_s, buf_push_s, buf_pop_s;

    // Occupancy, credit and handshake decisions from registered state.
    always_comb begin
        count_s   = wr_ptr_r - free_ptr_r;
        full_s    = (count_s == DEPTH);
        push_ok_s = WR_PUSH && !full_s;
        DSC_VALID = (buf_cnt_r != 2'd0) || s2_vld_r;
        pop_s     = DSC_VALID && DSC_READY;
        occ_s     = buf_cnt_r + {1'b0, s1_vld_r} + {1'b0, s2_vld_r};
        // A pop this cycle returns one credit, which is what lets the pipe stream at one per cycle.
        issue_s   = !FLUSH && (iss_ptr_r != wr_ptr_r) && ((occ_s < 2'd2) || pop_s);
        buf_pop_s  = pop_s && (buf_cnt_r != 2'd0);
        buf_push_s = s2_vld_r && !(pop_s && (buf_cnt_r == 2'd0));
    end

    // Head selection: buffered entry first, otherwise the descriptor arriving from the SRAM this cycle.
    always_comb begin
        if (buf_cnt_r != 2'd0) begin
            DSC_DATA = buf_data_r[buf_rd_r];
            DSC_SLOT = buf_slot_r[buf_rd_r];
        end else if (s2_vld_r) begin
            DSC_DATA = RAM_R_DATA;
            DSC_SLOT = s2_slot_r;
        end else begin
            DSC_DATA = {DSC_WIDTH{1'b0}};
            DSC_SLOT = {SLOT_BITS{1'b0}};
        end
    end

    assign WR_SLOT       = wr_ptr_r[SLOT_BITS-1:0];
    assign WR_FULL       = full_s;
    assign COUNT         = count_s;
    assign OVF           = ovf_r;
    assign RAM_R_ADDR    = iss_ptr_r[SLOT_BITS-1:0];
    assign RAM_R_ADDR_EN = issue_s;
    assign RAM_R_DATA_EN = s1_vld_r;

    // Pointers, read pipe and output buffer state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r   <= {PW{1'b0}};
            iss_ptr_r  <= {PW{1'b0}};
            free_ptr_r <= {PW{1'b0}};
            ovf_r      <= 1'b0;
            s1_vld_r   <= 1'b0;
            s2_vld_r   <= 1'b0;
            s1_slot_r  <= {SLOT_BITS{1'b0}};
            s2_slot_r  <= {SLOT_BITS{1'b0}};
            buf_rd_r   <= 1'b0;
            buf_wr_r   <= 1'b0;
            buf_cnt_r  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_r[i] <= {DSC_WIDTH{1'b0}};
                buf_slot_r[i] <= {SLOT_BITS{1'b0}};
            end
        end else begin
            if (WR_PUSH && full_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
            if (FLUSH) begin
                wr_ptr_r   <= {PW{1'b0}};
                iss_ptr_r  <= {PW{1'b0}};
                free_ptr_r <= {PW{1'b0}};
                s1_vld_r   <= 1'b0;
                s2_vld_r   <= 1'b0;
                buf_rd_r   <= 1'b0;
                buf_wr_r   <= 1'b0;
                buf_cnt_r  <= 2'd0;
            end else begin
                wr_ptr_r   <= wr_ptr_r + {{SLOT_BITS{1'b0}}, push_ok_s};
                iss_ptr_r  <= iss_ptr_r + {{SLOT_BITS{1'b0}}, issue_s};
                free_ptr_r <= free_ptr_r + {{SLOT_BITS{1'b0}}, pop_s};
                s1_vld_r   <= issue_s;
                s1_slot_r  <= iss_ptr_r[SLOT_BITS-1:0];
                s2_vld_r   <= s1_vld_r;
                s2_slot_r  <= s1_slot_r;
                if (buf_push_s) begin
                    buf_data_r[buf_wr_r] <= RAM_R_DATA;
                    buf_slot_r[buf_wr_r] <= s2_slot_r;
                    buf_wr_r             <= ~buf_wr_r;
                end else begin
                    buf_wr_r <= buf_wr_r;
                end
                if (buf_pop_s) begin
                    buf_rd_r <= ~buf_rd_r;
                end else begin
                    buf_rd_r <= buf_rd_r;
                end
                buf_cnt_r <= buf_cnt_r + {1'b0, buf_push_s} - {1'b0, buf_pop_s};
            end
        end
    end

endmodule

// File: tb/tb_dsc_cache_reader.sv
// Randomized bench for dsc_cache_reader: a behavioural SRAM plus a queue-based reference model
// of pushed descriptors, slot usage and occupancy.
module tb_dsc_cache_reader;

    localparam int DW = 88;
    localparam int SB = 2;

    logic          CLK = 1'b0;
    logic          RESET, FLUSH, WR_PUSH, DSC_READY;
    logic [SB-1:0] WR_SLOT, RAM_R_ADDR, DSC_SLOT;
    logic          WR_FULL, OVF, RAM_R_ADDR_EN, RAM_R_DATA_EN, DSC_VALID;
    logic [DW-1:0] RAM_R_DATA, DSC_DATA, wr_data;
    logic [SB:0]   COUNT;

    dsc_cache_reader #(.DSC_WIDTH(DW), .SLOT_BITS(SB)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .WR_PUSH(WR_PUSH), .WR_SLOT(WR_SLOT),
        .WR_FULL(WR_FULL), .OVF(OVF), .RAM_R_ADDR(RAM_R_ADDR), .RAM_R_ADDR_EN(RAM_R_ADDR_EN),
        .RAM_R_DATA_EN(RAM_R_DATA_EN), .RAM_R_DATA(RAM_R_DATA), .DSC_VALID(DSC_VALID),
        .DSC_READY(DSC_READY), .DSC_DATA(DSC_DATA), .DSC_SLOT(DSC_SLOT), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM: registered address, registered read data.
    logic [DW-1:0] mem [4];
    logic [SB-1:0] ram_addr_q;
    always @(posedge CLK) begin
        if (WR_PUSH && !WR_FULL) mem[WR_SLOT] <= wr_data;
        if (RAM_R_ADDR_EN) ram_addr_q <= RAM_R_ADDR;
        if (RAM_R_DATA_EN) RAM_R_DATA <= mem[ram_addr_q];
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SB-1:0] slot;
    } item_t;

    item_t         exp_q[$];
    item_t         seen_q[$];
    int unsigned   push_cnt, iss_cnt, pop_cnt, mdl_cnt;
    bit            mdl_ovf, prev_stall;
    logic [DW-1:0] prev_data;
    logic [SB-1:0] prev_slot;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic          last_addr_en, last_data_en, last_valid;
    logic [SB-1:0] last_addr, last_slot, last_wr_slot;
    logic [SB:0]   last_count;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_clear();
        exp_q.delete();
        push_cnt   = 0;
        iss_cnt    = 0;
        pop_cnt    = 0;
        mdl_cnt    = 0;
        prev_stall = 1'b0;
    endtask

    task automatic rand_data();
        wr_data = DW'({$urandom(), $urandom(), $urandom()});
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic tick();
        item_t       it;
        int unsigned cnt0;
        #1;
        cnt0         = mdl_cnt;
        last_addr_en = RAM_R_ADDR_EN;
        last_addr    = RAM_R_ADDR;
        last_data_en = RAM_R_DATA_EN;
        last_valid   = DSC_VALID;
        last_slot    = DSC_SLOT;
        last_count   = COUNT;
        last_wr_slot = WR_SLOT;
        chk_eq("count", COUNT, cnt0);
        chk_eq("full", WR_FULL, cnt0 == 4);
        chk_eq("wr_slot", WR_SLOT, push_cnt % 4);
        chk_eq("ovf", OVF, mdl_ovf);
        if (prev_stall) begin
            chk_eq("stall_valid", DSC_VALID, 1'b1);
            chk_eq("stall_data", DSC_DATA, prev_data);
            chk_eq("stall_slot", DSC_SLOT, prev_slot);
        end
        if (RAM_R_ADDR_EN) begin
            chk_eq("iss_addr", RAM_R_ADDR, iss_cnt % 4);
            chk_eq("iss_avail", iss_cnt < push_cnt, 1'b1);
            iss_cnt++;
        end
        if (DSC_VALID && DSC_READY) begin
            if (exp_q.size() == 0) begin
                chk_eq("spurious_dsc", DSC_VALID, 1'b0);
            end else begin
                it = exp_q.pop_front();
                chk_eq("dsc_data", DSC_DATA, it.data);
                chk_eq("dsc_slot", DSC_SLOT, it.slot);
                it.data = DSC_DATA;
                it.slot = DSC_SLOT;
                seen_q.push_back(it);
                pop_cnt++;
                mdl_cnt--;
            end
        end
        chk_eq("occupancy", (iss_cnt - pop_cnt) <= 2, 1'b1);
        prev_stall = DSC_VALID && !DSC_READY && !FLUSH;
        prev_data  = DSC_DATA;
        prev_slot  = DSC_SLOT;
        if (WR_PUSH) begin
            if (cnt0 < 4) begin
                it.data = wr_data;
                it.slot = SB'(push_cnt % 4);
                exp_q.push_back(it);
                push_cnt++;
                mdl_cnt++;
            end else begin
                mdl_ovf = 1'b1;
            end
        end
        if (FLUSH) mdl_clear();
        @(negedge CLK);
    endtask

    task automatic drain();
        WR_PUSH   = 1'b0;
        FLUSH     = 1'b0;
        DSC_READY = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk_eq("drain_left", exp_q.size(), 0);
        tick();
    endtask

    task automatic rst_checks(input string tag);
        chk_eq({tag, "_valid"}, DSC_VALID, 1'b0);
        chk_eq({tag, "_data"}, DSC_DATA, 0);
        chk_eq({tag, "_dslot"}, DSC_SLOT, 0);
        chk_eq({tag, "_aen"}, RAM_R_ADDR_EN, 1'b0);
        chk_eq({tag, "_den"}, RAM_R_DATA_EN, 1'b0);
        chk_eq({tag, "_addr"}, RAM_R_ADDR, 0);
        chk_eq({tag, "_full"}, WR_FULL, 1'b0);
        chk_eq({tag, "_count"}, COUNT, 0);
        chk_eq({tag, "_wslot"}, WR_SLOT, 0);
        chk_eq({tag, "_ovf"}, OVF, 1'b0);
    endtask

    initial begin
        int unsigned k, iss0;
        RESET = 1'b1; FLUSH = 1'b0; WR_PUSH = 1'b0; DSC_READY = 1'b0; wr_data = '0;
        mdl_clear();
        mdl_ovf = 1'b0;
        @(negedge CLK);
        #1 rst_checks("rst");
        @(negedge CLK);
        RESET = 1'b0;

        // Single descriptor latency: issue +1, data enable +2, valid +3.
        DSC_READY = 1'b1; WR_PUSH = 1'b1; rand_data();
        tick(); chk_eq("t1_aen_c0", last_addr_en, 1'b0);
        WR_PUSH = 1'b0;
        tick(); chk_eq("t1_aen_c1", last_addr_en, 1'b1); chk_eq("t1_addr_c1", last_addr, 0);
        tick(); chk_eq("t1_den_c2", last_data_en, 1'b1);
        tick(); chk_eq("t1_valid_c3", last_valid, 1'b1); chk_eq("t1_slot_c3", last_slot, 0);
        chk_eq("t1_count_c3", last_count, 1);
        tick(); chk_eq("t1_count_c4", last_count, 0); chk_eq("t1_valid_c4", last_valid, 1'b0);

        // Back-to-back pushes stream one descriptor per cycle.
        for (int c = 0; c < 10; c++) begin
            WR_PUSH = (c < 6);
            rand_data();
            tick();
            if (c >= 3 && c <= 8) chk_eq("t2_stream_valid", last_valid, 1'b1);
        end
        drain();

        // Fill with downstream stalled: only two reads go out, fifth push overflows.
        DSC_READY = 1'b0;
        iss0 = iss_cnt;
        for (int c = 0; c < 8; c++) begin
            WR_PUSH = (c < 5);
            rand_data();
            tick();
        end
        chk_eq("t3_count", last_count, 4);
        chk_eq("t3_full", WR_FULL, 1'b1);
        chk_eq("t3_ovf", OVF, 1'b1);
        chk_eq("t3_reads", iss_cnt - iss0, 2);
        drain();

        // Flush one cycle after a read issue with three slots occupied.
        FLUSH = 1'b1; tick(); FLUSH = 1'b0;
        DSC_READY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            WR_PUSH = 1'b1; rand_data(); tick();
        end
        WR_PUSH = 1'b0; FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0; DSC_READY = 1'b1;
        tick();
        chk_eq("t4_valid", last_valid, 1'b0);
        chk_eq("t4_count", last_count, 0);
        chk_eq("t4_wslot", last_wr_slot, 0);
        for (int c = 0; c < 4; c++) begin
            tick(); chk_eq("t4_late_valid", last_valid, 1'b0);
        end

        // Six descriptors 1..6 with pops interleaved, across the slot wrap.
        seen_q.delete();
        k = 0;
        for (int c = 0; c < 60 && !(k == 6 && exp_q.size() == 0); c++) begin
            WR_PUSH   = (k < 6) && (mdl_cnt < 4);
            wr_data   = DW'(k + 1);
            DSC_READY = c[0];
            if (WR_PUSH) k++;
            tick();
        end
        WR_PUSH = 1'b0;
        chk_eq("t5_seen", seen_q.size(), 6);
        for (int i = 0; i < 6 && i < seen_q.size(); i++) begin
            chk_eq("t5_order", seen_q[i].data, i + 1);
            chk_eq("t5_slotseq", seen_q[i].slot, i % 4);
        end
        drain();

        // Random traffic: ready toggling, then random ready with occasional flushes.
        for (int c = 0; c < 600; c++) begin
            WR_PUSH   = ($urandom_range(9) < 6) && (mdl_cnt < 4);
            rand_data();
            DSC_READY = (c < 300) ? c[0] : ($urandom_range(3) != 0);
            FLUSH     = (c >= 300) && ($urandom_range(99) == 0);
            tick();
        end
        drain();

        // Asynchronous reset mid-stream.
        DSC_READY = 1'b1;
        for (int c = 0; c < 5; c++) begin
            WR_PUSH = 1'b1; rand_data(); tick();
        end
        WR_PUSH = 1'b0;
        #3 RESET = 1'b1;
        #1 rst_checks("t7_rst");
        @(negedge CLK);
        RESET = 1'b0;
        mdl_clear();
        mdl_ovf = 1'b0;
        WR_PUSH = 1'b1; rand_data();
        tick(); chk_eq("t7_first_slot", last_wr_slot, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
